// File: rtl/mem_stage_if.sv
// Bundle of EX->MEM, SRAM response, and MEM->WB/ID signals around mem_stage.
// Master drives the stage inputs; slave is the MEM stage itself.
interface mem_stage_if;
   logic        es2ms_valid;
   logic        ms_allowin;
   logic [31:0] es_pc;
   logic        es_mem_req;
   logic [4:0]  es_ld_op;
   logic        es_rf_we;
   logic [4:0]  es_rf_waddr;
   logic [31:0] es_result;
   logic [6:0]  es_except;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ws_allowin;
   logic        ms2ws_valid;
   logic [31:0] ms_pc;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic [6:0]  ms_except;
   logic        ms_ex;
   logic [38:0] ms_rf_zip;
   logic        wb_ex;

   modport master (
      output es2ms_valid, es_pc, es_mem_req, es_ld_op,
      output es_rf_we, es_rf_waddr, es_result, es_except,
      output data_sram_data_ok, data_sram_rdata,
      output ws_allowin, wb_ex,
      input  ms_allowin, ms2ws_valid, ms_pc, ms_rf_we,
      input  ms_rf_waddr, ms_rf_wdata, ms_except, ms_ex, ms_rf_zip
   );

   modport slave (
      input  es2ms_valid, es_pc, es_mem_req, es_ld_op,
      input  es_rf_we, es_rf_waddr, es_result, es_except,
      input  data_sram_data_ok, data_sram_rdata,
      input  ws_allowin, wb_ex,
      output ms_allowin, ms2ws_valid, ms_pc, ms_rf_we,
      output ms_rf_waddr, ms_rf_wdata, ms_except, ms_ex, ms_rf_zip
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM response, buffers it under WB
// backpressure, extends load data, and drops responses orphaned by flushes.
module mem_stage (
   input logic       clk,
   input logic       resetn,
   mem_stage_if.slave bus
);

   logic        ms_valid_q;
   logic [31:0] ms_pc_q;
   logic        ms_mem_req_q;
   logic [4:0]  ms_ld_op_q;
   logic        ms_rf_we_q;
   logic [4:0]  ms_rf_waddr_q;
   logic [31:0] ms_result_q;
   logic [6:0]  ms_except_q;
   logic        buf_valid_q;
   logic [31:0] buf_data_q;
   logic [1:0]  cancel_cnt_q;
   logic [1:0]  cancel_cnt_d;

   logic        cnt_zero;
   logic        data_ok_live;
   logic        ready_go;
   logic        allowin;
   logic        to_ws;
   logic        es_go;
   logic        buf_set;
   logic        buf_clr;
   logic        inc_ms;
   logic        inc_es;
   logic        dec_ok;
   logic [2:0]  cnt_sum;
   logic [31:0] ld_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] rf_wdata;
   logic        ld_wait;

   assign cnt_zero     = (cancel_cnt_q == 2'd0);
   assign data_ok_live = bus.data_sram_data_ok & cnt_zero;
   assign ready_go     = ~ms_mem_req_q | buf_valid_q | data_ok_live;
   assign allowin      = ~ms_valid_q | (ready_go & bus.ws_allowin);
   assign to_ws        = ms_valid_q & ready_go;
   assign es_go        = bus.es2ms_valid & allowin;
   assign buf_set      = data_ok_live & ms_valid_q & ms_mem_req_q
                       & ~buf_valid_q & ~bus.ws_allowin;
   assign buf_clr      = bus.wb_ex | (to_ws & bus.ws_allowin);

   // Responses still owed to flushed requests must be swallowed later.
   assign inc_ms = bus.wb_ex & ms_valid_q & ms_mem_req_q
                 & ~buf_valid_q & ~bus.data_sram_data_ok;
   assign inc_es = bus.wb_ex & es_go & bus.es_mem_req;
   assign dec_ok = bus.data_sram_data_ok & ~cnt_zero;

   always_comb begin
      cnt_sum = {1'b0, cancel_cnt_q} + {2'b00, inc_ms}
              + {2'b00, inc_es} - {2'b00, dec_ok};
      cancel_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
   end

   assign ld_data  = buf_valid_q ? buf_data_q : bus.data_sram_rdata;
   assign half_sel = ms_result_q[1] ? ld_data[31:16] : ld_data[15:0];

   always_comb begin
      byte_sel = ld_data[7:0];
      unique case (ms_result_q[1:0])
         2'd0: byte_sel = ld_data[7:0];
         2'd1: byte_sel = ld_data[15:8];
         2'd2: byte_sel = ld_data[23:16];
         2'd3: byte_sel = ld_data[31:24];
         default: byte_sel = ld_data[7:0];
      endcase
   end

   always_comb begin
      rf_wdata = ms_result_q;
      unique case (1'b1)
         ms_ld_op_q[4]: rf_wdata = {{24{byte_sel[7]}}, byte_sel};
         ms_ld_op_q[3]: rf_wdata = {24'b0, byte_sel};
         ms_ld_op_q[2]: rf_wdata = {{16{half_sel[15]}}, half_sel};
         ms_ld_op_q[1]: rf_wdata = {16'b0, half_sel};
         ms_ld_op_q[0]: rf_wdata = ld_data;
         default:       rf_wdata = ms_result_q;
      endcase
   end

   assign ld_wait = ms_valid_q & (|ms_ld_op_q) & ~ready_go;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q    <= 1'b0;
         ms_pc_q       <= 32'b0;
         ms_mem_req_q  <= 1'b0;
         ms_ld_op_q    <= 5'b0;
         ms_rf_we_q    <= 1'b0;
         ms_rf_waddr_q <= 5'b0;
         ms_result_q   <= 32'b0;
         ms_except_q   <= 7'b0;
         buf_valid_q   <= 1'b0;
         buf_data_q    <= 32'b0;
         cancel_cnt_q  <= 2'd0;
      end else begin
         if (bus.wb_ex) begin
            ms_valid_q <= 1'b0;
         end else if (allowin) begin
            ms_valid_q <= bus.es2ms_valid;
         end
         if (es_go) begin
            ms_pc_q       <= bus.es_pc;
            ms_mem_req_q  <= bus.es_mem_req;
            ms_ld_op_q    <= bus.es_ld_op;
            ms_rf_we_q    <= bus.es_rf_we;
            ms_rf_waddr_q <= bus.es_rf_waddr;
            ms_result_q   <= bus.es_result;
            ms_except_q   <= bus.es_except;
         end
         if (buf_clr) begin
            buf_valid_q <= 1'b0;
         end else if (buf_set) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= bus.data_sram_rdata;
         end
         cancel_cnt_q <= cancel_cnt_d;
      end
   end

   assign bus.ms_allowin  = allowin;
   assign bus.ms2ws_valid = to_ws;
   assign bus.ms_pc       = ms_pc_q;
   assign bus.ms_rf_we    = ms_rf_we_q;
   assign bus.ms_rf_waddr = ms_rf_waddr_q;
   assign bus.ms_rf_wdata = rf_wdata;
   assign bus.ms_except   = ms_except_q;
   assign bus.ms_ex       = ms_valid_q & (|ms_except_q);
   assign bus.ms_rf_zip   = {ld_wait, ms_rf_we_q & ms_valid_q,
                             ms_rf_waddr_q, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, extension, buffering, flush
// cancellation, exceptions, back-to-back flow and async reset.
module tb_mem_stage;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   mem_stage_if bus ();

   mem_stage dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic mreq,
                       input logic [4:0] ldop, input logic we,
                       input logic [4:0] wa, input logic [31:0] res,
                       input logic [6:0] exc);
      bus.es2ms_valid = 1'b1;
      bus.es_pc       = pc;
      bus.es_mem_req  = mreq;
      bus.es_ld_op    = ldop;
      bus.es_rf_we    = we;
      bus.es_rf_waddr = wa;
      bus.es_result   = res;
      bus.es_except   = exc;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      step();
      step();
      checks++;
      if (bus.ms2ws_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b exp=0", bus.ms2ws_valid);
      end
      checks++;
      if (bus.ms_allowin !== 1'b1) begin
         failures++;
         $display("FAIL reset_allowin got=%b exp=1", bus.ms_allowin);
      end
      checks++;
      if (bus.ms_rf_zip !== 39'b0) begin
         failures++;
         $display("FAIL reset_zip got=%h exp=0", bus.ms_rf_zip);
      end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_ld_w;
      send(32'h0000_0040, 1'b1, 5'b00001, 1'b1, 5'd3, 32'h100, 7'b0);
      step();
      bus.es2ms_valid = 1'b0;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b0 || bus.ms_rf_zip[38] !== 1'b1) begin
         failures++;
         $display("FAIL ldw_wait got=%b/%b exp=0/1",
                  bus.ms2ws_valid, bus.ms_rf_zip[38]);
      end
      step();
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h89AB_CDEF;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b1) begin
         failures++;
         $display("FAIL ldw_valid got=%b exp=1", bus.ms2ws_valid);
      end
      checks++;
      if (bus.ms_rf_wdata !== 32'h89AB_CDEF) begin
         failures++;
         $display("FAIL ldw_data got=%h exp=89abcdef", bus.ms_rf_wdata);
      end
      checks++;
      if (bus.ms_rf_zip[38:32] !== 7'b0100011) begin
         failures++;
         $display("FAIL ldw_zip got=%b exp=0100011", bus.ms_rf_zip[38:32]);
      end
      step();
      bus.data_sram_data_ok = 1'b0;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b0) begin
         failures++;
         $display("FAIL ldw_drain got=%b exp=0", bus.ms2ws_valid);
      end
   endtask

   task automatic test_extend;
      logic [4:0]  op  [6];
      logic [31:0] adr [6];
      logic [31:0] exp [6];
      op[0] = 5'b10000; adr[0] = 32'h503; exp[0] = 32'hFFFF_FF80;
      op[1] = 5'b01000; adr[1] = 32'h503; exp[1] = 32'h0000_0080;
      op[2] = 5'b00100; adr[2] = 32'h502; exp[2] = 32'hFFFF_8011;
      op[3] = 5'b00010; adr[3] = 32'h502; exp[3] = 32'h0000_8011;
      op[4] = 5'b10000; adr[4] = 32'h501; exp[4] = 32'h0000_0022;
      op[5] = 5'b00100; adr[5] = 32'h500; exp[5] = 32'h0000_2233;
      for (int i = 0; i < 6; i++) begin
         bus.data_sram_data_ok = 1'b0;
         send(32'h0000_0080, 1'b1, op[i], 1'b1, 5'd4, adr[i], 7'b0);
         step();
         bus.es2ms_valid       = 1'b0;
         bus.data_sram_data_ok = 1'b1;
         bus.data_sram_rdata   = 32'h8011_2233;
         #1;
         checks++;
         if (bus.ms2ws_valid !== 1'b1 || bus.ms_rf_wdata !== exp[i]) begin
            failures++;
            $display("FAIL ext_%0d got=%b/%h exp=1/%h", i,
                     bus.ms2ws_valid, bus.ms_rf_wdata, exp[i]);
         end
         step();
      end
      bus.data_sram_data_ok = 1'b0;
   endtask

   task automatic test_buffer;
      send(32'h0000_00C0, 1'b1, 5'b00001, 1'b1, 5'd6, 32'h600, 7'b0);
      step();
      bus.es2ms_valid       = 1'b0;
      bus.ws_allowin        = 1'b0;
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h1234_5678;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b1 || bus.ms_allowin !== 1'b0) begin
         failures++;
         $display("FAIL buf_first got=%b/%b exp=1/0",
                  bus.ms2ws_valid, bus.ms_allowin);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         bus.data_sram_data_ok = 1'b0;
         bus.data_sram_rdata   = 32'hDEAD_BEEF;
         #1;
         checks++;
         if (bus.ms2ws_valid !== 1'b1 || bus.ms_allowin !== 1'b0 ||
             bus.ms_rf_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL buf_hold_%0d got=%b/%b/%h exp=1/0/12345678", i,
                     bus.ms2ws_valid, bus.ms_allowin, bus.ms_rf_wdata);
         end
      end
      bus.ws_allowin = 1'b1;
      #1;
      checks++;
      if (bus.ms_allowin !== 1'b1) begin
         failures++;
         $display("FAIL buf_release got=%b exp=1", bus.ms_allowin);
      end
      step();
      send(32'h0000_00C4, 1'b1, 5'b00001, 1'b1, 5'd6, 32'h604, 7'b0);
      step();
      bus.es2ms_valid = 1'b0;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b0 || bus.ms_rf_zip[38] !== 1'b1) begin
         failures++;
         $display("FAIL buf_cleared got=%b/%b exp=0/1",
                  bus.ms2ws_valid, bus.ms_rf_zip[38]);
      end
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h0BAD_F00D;
      #1;
      checks++;
      if (bus.ms_rf_wdata !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL buf_next got=%h exp=0badf00d", bus.ms_rf_wdata);
      end
      step();
      bus.data_sram_data_ok = 1'b0;
   endtask

   task automatic test_flush;
      send(32'h0000_0100, 1'b1, 5'b00001, 1'b1, 5'd8, 32'h200, 7'b0);
      step();
      send(32'h0000_0104, 1'b1, 5'b00000, 1'b0, 5'd0, 32'h204, 7'b0);
      bus.wb_ex = 1'b1;
      #1;
      checks++;
      if (bus.ms_allowin !== 1'b0) begin
         failures++;
         $display("FAIL flush_block got=%b exp=0", bus.ms_allowin);
      end
      step();
      checks++;
      if (bus.ms2ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1) begin
         failures++;
         $display("FAIL flush_clear got=%b/%b exp=0/1",
                  bus.ms2ws_valid, bus.ms_allowin);
      end
      step();
      bus.wb_ex = 1'b0;
      send(32'h0000_0300, 1'b1, 5'b00001, 1'b1, 5'd7, 32'h300, 7'b0);
      step();
      bus.es2ms_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.data_sram_data_ok = 1'b1;
         bus.data_sram_rdata   = 32'hAAAA_0001 + i;
         #1;
         checks++;
         if (bus.ms2ws_valid !== 1'b0 || bus.ms_rf_zip[38] !== 1'b1) begin
            failures++;
            $display("FAIL flush_drop_%0d got=%b/%b exp=0/1", i,
                     bus.ms2ws_valid, bus.ms_rf_zip[38]);
         end
         step();
      end
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h5555_CCCC;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b1 || bus.ms_rf_wdata !== 32'h5555_CCCC) begin
         failures++;
         $display("FAIL flush_third got=%b/%h exp=1/5555cccc",
                  bus.ms2ws_valid, bus.ms_rf_wdata);
      end
      step();
      bus.data_sram_data_ok = 1'b0;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_done got=%b exp=0", bus.ms2ws_valid);
      end
   endtask

   task automatic test_except;
      send(32'h0000_1000, 1'b0, 5'b0, 1'b1, 5'd5, 32'hCAFE_F00D, 7'b0000100);
      step();
      bus.es2ms_valid = 1'b0;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b1 || bus.ms_ex !== 1'b1) begin
         failures++;
         $display("FAIL exc_flags got=%b/%b exp=1/1",
                  bus.ms2ws_valid, bus.ms_ex);
      end
      checks++;
      if (bus.ms_rf_wdata !== 32'hCAFE_F00D || bus.ms_except !== 7'b0000100 ||
          bus.ms_pc !== 32'h0000_1000) begin
         failures++;
         $display("FAIL exc_bus got=%h/%b/%h exp=cafef00d/0000100/00001000",
                  bus.ms_rf_wdata, bus.ms_except, bus.ms_pc);
      end
      step();
      checks++;
      if (bus.ms_ex !== 1'b0) begin
         failures++;
         $display("FAIL exc_gone got=%b exp=0", bus.ms_ex);
      end
   endtask

   task automatic test_back_to_back;
      send(32'h0000_2000, 1'b0, 5'b0, 1'b1, 5'd9, 32'h1111_1111, 7'b0);
      step();
      send(32'h0000_2004, 1'b0, 5'b0, 1'b1, 5'd10, 32'h2222_2222, 7'b0);
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b1 || bus.ms_rf_wdata !== 32'h1111_1111 ||
          bus.ms_allowin !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first got=%b/%h exp=1/11111111",
                  bus.ms2ws_valid, bus.ms_rf_wdata);
      end
      step();
      bus.es2ms_valid = 1'b0;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b1 || bus.ms_rf_wdata !== 32'h2222_2222 ||
          bus.ms_rf_waddr !== 5'd10) begin
         failures++;
         $display("FAIL b2b_second got=%b/%h exp=1/22222222",
                  bus.ms2ws_valid, bus.ms_rf_wdata);
      end
      step();
   endtask

   task automatic test_async_reset;
      send(32'h0000_3000, 1'b1, 5'b00001, 1'b1, 5'd11, 32'h700, 7'b0000010);
      step();
      bus.es2ms_valid = 1'b0;
      #1;
      checks++;
      if (bus.ms_rf_zip[38] !== 1'b1) begin
         failures++;
         $display("FAIL arst_pending got=%b exp=1", bus.ms_rf_zip[38]);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.ms2ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1 ||
          bus.ms_ex !== 1'b0) begin
         failures++;
         $display("FAIL arst_ctrl got=%b/%b/%b exp=0/1/0",
                  bus.ms2ws_valid, bus.ms_allowin, bus.ms_ex);
      end
      checks++;
      if (bus.ms_rf_zip !== 39'b0 || bus.ms_pc !== 32'b0 ||
          bus.ms_except !== 7'b0) begin
         failures++;
         $display("FAIL arst_bus got=%h/%h/%b exp=0/0/0",
                  bus.ms_rf_zip, bus.ms_pc, bus.ms_except);
      end
      step();
      resetn = 1'b1;
      step();
   endtask

   initial begin
      checks                = 0;
      failures              = 0;
      resetn                = 1'b0;
      bus.es2ms_valid       = 1'b0;
      bus.es_pc             = 32'b0;
      bus.es_mem_req        = 1'b0;
      bus.es_ld_op          = 5'b0;
      bus.es_rf_we          = 1'b0;
      bus.es_rf_waddr       = 5'b0;
      bus.es_result         = 32'b0;
      bus.es_except         = 7'b0;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = 32'b0;
      bus.ws_allowin        = 1'b1;
      bus.wb_ex             = 1'b0;
      test_reset();
      test_ld_w();
      test_extend();
      test_buffer();
      test_flush();
      test_except();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 No parameters; all widths fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 es2ms_valid  in  1  EX holds a valid instruction ready to transfer.
REQ-005 ms_allowin  out  1  MEM can accept an instruction this cycle.
REQ-006 es_pc  in  32  instruction PC.
REQ-007 es_mem_req  in  1  instruction issued a data-SRAM request that was accepted (addr_ok) in EX.
REQ-008 es_ld_op  in  5  {ld_b, ld_bu, ld_h, ld_hu, ld_w}, one-hot or zero.
REQ-009 es_rf_we / es_rf_waddr / es_result  in  1/5/32  writeback enable, destination, ALU/counter result (also the load address).
REQ-010 es_except  in  7  exception flags carried from earlier stages.
REQ-011 data_sram_data_ok / data_sram_rdata  in  1/32  read/write response pulse and read data.
REQ-012 ws_allowin  in  1  WB can accept.
REQ-013 ms2ws_valid  out  1  MEM instruction complete and valid.
REQ-014 ms_pc / ms_rf_we / ms_rf_waddr / ms_rf_wdata / ms_except  out  32/1/5/32/7  bus to WB.
REQ-015 ms_ex  out  1  ms_valid & |ms_except.
REQ-016 ms_rf_zip  out  39  {ms_ld_wait, ms_rf_we & ms_valid, ms_rf_waddr, ms_rf_wdata} for ID bypass/stall.
REQ-017 wb_ex  in  1  flush from WB.

Function
REQ-018 ms_valid: cleared by wb_ex; otherwise loaded with es2ms_valid when ms_allowin.
REQ-019 Payload registers capture all es_* inputs only when es2ms_valid & ms_allowin.
REQ-020 ms_ready_go = ~ms_mem_req | buf_valid | (data_sram_data_ok & cancel_cnt==0).
REQ-021 ms_allowin = ~ms_valid | ms_ready_go & ws_allowin; ms2ws_valid = ms_valid & ms_ready_go.
REQ-022 Data buffer: data_ok with cancel_cnt==0 while ms_valid & ms_mem_req & ~buf_valid & ~ws_allowin latches rdata into buf_data and sets buf_valid.
REQ-023 buf_valid clears when MEM transfers to WB (ms2ws_valid & ws_allowin) or on wb_ex.
REQ-024 Load data source: buf_data if buf_valid, else data_sram_rdata.
REQ-025 Load extension by ms_result[1:0]: ld_b/ld_bu select byte [8*a+7:8*a], sign-/zero-extend; ld_h/ld_hu select half [31:16] if a[1] else [15:0]; ld_w full word.
REQ-026 ms_rf_wdata = extended load data if any es_ld_op bit set, else ms_result.
REQ-027 ms_ld_wait = ms_valid & (|ms_ld_op) & ~ms_ready_go.
REQ-028 Cancel counter cancel_cnt (2 bits): on wb_ex, add 1 if ms_valid & ms_mem_req & ~buf_valid & ~data_ok-this-cycle, plus 1 if es2ms_valid & ms_allowin & es_mem_req.
REQ-029 Each data_ok while cancel_cnt>0 decrements by 1 and is discarded (no buffer, no ready_go); simultaneous increment and decrement apply net; saturate at 3.
REQ-030 Outputs carry payload registers directly; WB handles masking by ms_ex.

Reset
REQ-031 Asynchronous reset clears ms_valid, buf_valid, cancel_cnt, buf_data and all payload registers to 0; ms2ws_valid=0, ms_allowin=1 immediately.
REQ-032 Reset asserted mid-request discards the outstanding response state (cancel_cnt=0); the SRAM side is reset together with the core.

Verification
REQ-033 ld_w, addr 0x100, data_ok one cycle after transfer, rdata 0x89ABCDEF, ws_allowin=1 -> ms2ws_valid that cycle, ms_rf_wdata=0x89ABCDEF.
REQ-034 ld_b addr ...3 rdata 0x80112233 -> 0xFFFFFF80; ld_bu -> 0x00000080; ld_h addr ...2 -> 0xFFFF8011; ld_hu -> 0x00008011.
REQ-035 data_ok with ws_allowin=0 for 3 cycles -> buf_valid=1, ms_allowin=0, data held; ws_allowin=1 -> transfer, buf_valid=0.
REQ-036 wb_ex while load waiting and EX transferring a store -> cancel_cnt=2, ms_valid=0; next two data_ok discarded, third data_ok completes new load.
REQ-037 Non-memory op with es_except=7'b0000100 -> ms2ws_valid next cycle, ms_ex=1, ms_rf_wdata=es_result.
REQ-038 resetn low during pending load -> all outputs zero asynchronously, ms_allowin=1.
